// File: rtl/sobel_line_packer.sv
// sobel_line_packer: packs the 1-bit Sobel edge stream into fixed-length byte
// packets, one per image line: 2-byte big-endian line number, then
// IMAGE_WIDTH/8 pixel bytes, MSB-first. Short lines are zero-padded, long
// lines are truncated, so every started line yields exactly DATA_LENGTH bytes.
module sobel_line_packer #(
    parameter int IMAGE_WIDTH = 1280
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic       valid,
    input  logic       vsync,
    input  logic       sobel,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_last,
    output logic       frame_start,
    output logic       line_err
);

    localparam int DATA_LENGTH = IMAGE_WIDTH / 8 + 2;
    localparam int IDX_W       = $clog2(IMAGE_WIDTH + 1);
    localparam int CNT_W       = $clog2(DATA_LENGTH + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(IMAGE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, LINE, PAD} state_t;

    state_t           state_q;
    logic             vsync_q, vsync_prev_q;
    logic             valid_prev_q;
    logic             frame_pending_q;
    logic [15:0]      line_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       sr_q;
    logic             drop_q;
    logic [7:0]       byte_data_q;
    logic             byte_valid_q, byte_last_q, frame_start_q, line_err_q;

    logic             vsync_rise, start;
    logic [15:0]      hdr_line;
    logic [7:0]       partial_byte;
    logic             partial_due;
    logic [7:0]       byte_data_d;
    logic             byte_valid_d, byte_last_d;

    assign vsync_rise   = vsync_q & ~vsync_prev_q;
    // A line only begins on a fresh valid edge, so a line that overruns its
    // padding window cannot restart mid-stream.
    assign start        = (state_q == IDLE) && valid && !valid_prev_q;
    assign hdr_line     = frame_pending_q ? 16'h0000 : line_q;
    // Left-align the n collected bits of the partial byte, zero-filling below.
    assign partial_byte = {sr_q, 1'b0} << (3'd7 - idx_q[2:0]);
    assign partial_due  = (idx_q[2:0] != 3'd0) &&
                          (cnt_q == CNT_W'(2) + CNT_W'(idx_q >> 3));

    // Select the byte (if any) to be registered onto the output this cycle.
    always_comb begin
        byte_valid_d = 1'b0;
        byte_data_d  = 8'h00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = hdr_line[15:8];
                end
            end
            LINE: begin
                if (valid && idx_q != IDX_FULL) begin
                    if (idx_q == IDX_W'(1)) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = line_q[7:0];
                    end else if (idx_q[2:0] == 3'd7) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = {sr_q, sobel};
                    end
                end
            end
            PAD: begin
                byte_valid_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    byte_data_d = line_q[7:0];
                end else if (partial_due) begin
                    byte_data_d = partial_byte;
                end
            end
            default: ;
        endcase
        byte_last_d = byte_valid_d && (state_q != IDLE) && (cnt_q == CNT_LAST);
    end

    // Synchronise vsync and keep its previous value for edge detection.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            vsync_prev_q <= vsync_q;
        end
    end

    // Line FSM: pixel packing, padding, line numbering and registered outputs.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            valid_prev_q    <= 1'b0;
            frame_pending_q <= 1'b0;
            line_q          <= 16'h0000;
            idx_q           <= '0;
            cnt_q           <= '0;
            sr_q            <= '0;
            drop_q          <= 1'b0;
            byte_data_q     <= 8'h00;
            byte_valid_q    <= 1'b0;
            byte_last_q     <= 1'b0;
            frame_start_q   <= 1'b0;
            line_err_q      <= 1'b0;
        end else begin
            byte_data_q   <= byte_data_d;
            byte_valid_q  <= byte_valid_d;
            byte_last_q   <= byte_last_d;
            frame_start_q <= vsync_rise;
            line_err_q    <= 1'b0;
            valid_prev_q  <= valid;
            if (vsync_rise) frame_pending_q <= 1'b1;
            if (byte_valid_d) cnt_q <= cnt_q + CNT_W'(1);
            if (byte_last_d) line_q <= line_q + 16'h0001;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LINE;
                        idx_q   <= IDX_W'(1);
                        cnt_q   <= CNT_W'(1);
                        sr_q    <= {sr_q[5:0], sobel};
                        drop_q  <= 1'b0;
                        if (frame_pending_q) begin
                            line_q <= 16'h0000;
                            if (!vsync_rise) frame_pending_q <= 1'b0;
                        end
                    end
                end
                LINE: begin
                    if (valid) begin
                        if (idx_q != IDX_FULL) begin
                            sr_q  <= {sr_q[5:0], sobel};
                            idx_q <= idx_q + IDX_W'(1);
                        end else if (!drop_q) begin
                            line_err_q <= 1'b1;
                            drop_q     <= 1'b1;
                        end
                    end else if (idx_q == IDX_FULL) begin
                        state_q <= IDLE;
                    end else begin
                        line_err_q <= 1'b1;
                        state_q    <= PAD;
                    end
                end
                PAD: begin
                    if (valid && !drop_q) begin
                        line_err_q <= 1'b1;
                        drop_q     <= 1'b1;
                    end
                    if (byte_last_d) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign byte_last   = byte_last_q;
    assign frame_start = frame_start_q;
    assign line_err    = line_err_q;

endmodule

// File: doc/sobel_line_packer.md
# sobel_line_packer

Packs the 1-bit Sobel edge stream into byte-wide, fixed-length line packets for the Ethernet UDP transmitter. It sits between the Sobel filter output (`sobel`/`sobel_valid`/`sobel_vsync`) and the Ethernet send path, in the halved pixel-clock domain. Each image line becomes exactly DATA_LENGTH bytes: a 2-byte big-endian line number followed by IMAGE_WIDTH/8 packed pixel bytes.

## Interface
- IMAGE_WIDTH, 1280, pixels per line. Must be a multiple of 8 and at least 16.
- DATA_LENGTH, IMAGE_WIDTH/8+2, bytes per line packet. Not overridable independently.
- clk_pixel  in  1  halved pixel clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  pixel valid, high for each pixel of a line.
- vsync  in  1  frame sync, active high; the rising edge marks a new frame.
- sobel  in  1  edge pixel, sampled when valid=1.
- byte_data  out  8  packet byte.
- byte_valid  out  1  byte_data is valid this cycle.
- byte_last  out  1  final byte of a packet, qualified by byte_valid.
- frame_start  out  1  one-cycle pulse when a vsync rising edge is detected.
- line_err  out  1  one-cycle pulse on any malformed line.

## Operation
- All outputs are registered. Reset values: byte_data=0, byte_valid=0, byte_last=0, frame_start=0, line_err=0.
- Internal reset state: line counter=0, frame_pending=0, FSM=IDLE.
- vsync is registered once and edge-detected. On a rising edge: frame_start pulses and frame_pending is set.
- FSM states: IDLE, LINE, PAD.
- IDLE:
  - When valid=1, accept pixel 0 and go to LINE.
  - If frame_pending=1, the line counter is cleared to 0 for this line, and frame_pending is cleared.
- LINE:
  - A pixel index counter counts accepted pixels.
  - Bits shift MSB-first: pixel 8k lands in bit 7 of data byte k.
  - Pixels with index ≥ IMAGE_WIDTH are dropped; line_err pulses once per line for this.
  - When valid=0 with index=IMAGE_WIDTH, the packet is already complete; go to IDLE.
  - When valid=0 with index<IMAGE_WIDTH, line_err pulses and the FSM goes to PAD.
- PAD:
  - Emit the outstanding bytes one per cycle, in order:
    - the missing header byte, if the line had 1 pixel;
    - the partial data byte, zero-filled in its low bits;
    - 0x00 bytes until the byte count reaches DATA_LENGTH.
  - Then go to IDLE.
- Byte order within each packet:
  - byte 0 = line_num[15:8];
  - byte 1 = line_num[7:0];
  - bytes 2..DATA_LENGTH-1 = packed pixels.
- byte_last is set on byte DATA_LENGTH-1 only.
- The line counter increments by 1 in the cycle byte_last is emitted. It is 16-bit and wraps 0xFFFF→0x0000 without error.
- Every started line produces exactly DATA_LENGTH bytes. No packet is ever truncated.
- valid=1 during PAD: those pixels are dropped and line_err pulses once. The FSM returns to IDLE only after padding completes. A new line starts only at the next valid rising edge seen from IDLE.
- vsync rising during LINE or PAD: the current packet completes normally with its existing line number. Only frame_pending is set.
- Asserting rst_n low mid-packet clears everything immediately. No partial packet resumes after reset.

## Timing
- Latency is 1 cycle from pixel acceptance to the byte it completes:
  - header byte 0 appears the cycle after pixel 0;
  - header byte 1 appears the cycle after pixel 1;
  - data byte k appears the cycle after pixel 8k+7.
- With IMAGE_WIDTH ≥ 16, header and data bytes never collide.
- byte_valid is sparse during LINE: 2 header cycles, then one byte per 8 pixels.
- During PAD, byte_valid is high every cycle.
- PAD duration is at most DATA_LENGTH-1 cycles. Upstream horizontal blanking must cover this, otherwise pixels are dropped as specified above.
- frame_start is high 2 cycles after the vsync rising edge at the pin (1 sync register + 1 output register).
- There is no backpressure. The downstream consumer must accept every byte_valid cycle.

## Test plan
- Normal line, IMAGE_WIDTH=16, first line after reset, 16 pixels with sobel=1,0 alternating:
  - bytes 0x00,0x00,0xAA,0xAA;
  - byte_last on the 4th byte;
  - each byte 1 cycle after its completing pixel;
  - next line carries header 0x00,0x01.
- Frame reset: 3 lines, then vsync pulse, then 1 line:
  - frame_start pulses once, 2 cycles after the vsync edge;
  - the 4th packet header is 0x0000.
- Short line, IMAGE_WIDTH=16, 5 pixels all 1:
  - line_err pulses;
  - PAD emits 0xF8, then 0x00;
  - the packet totals 4 bytes with byte_last on the final byte.
- Single-pixel line:
  - PAD emits header low byte, then 0x00 (pixel=0) or 0x80 (pixel=1), then 0x00;
  - exactly 4 bytes.
- Long line, 20 pixels:
  - 4-byte packet;
  - pixels 16–19 dropped;
  - a single line_err pulse.
- Robustness checks:
  - line counter preset near 0xFFFF (via 65536 short lines, or force) wraps to 0x0000;
  - valid reasserted during PAD drops those pixels with one line_err pulse;
  - rst_n pulsed mid-LINE: all outputs return to 0 asynchronously, and the next line header is 0x0000.
